// File: rtl/serial_transfer_unit_pkg.sv
// Shared constants for the Controller/Responder serial transfer handshake.
// State encodings and lane-mode values match the Controller side.
package serial_transfer_unit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    DONE     = 2'd2,
    WAIT_REL = 2'd3
  } xferState_e;

  localparam logic MODE_SERIAL = 1'b0;  // 1 bit per beat on DataOut[0]
  localparam logic MODE_DUAL   = 1'b1;  // 2 bits per beat on DataOut[1:0]

endpackage

// File: rtl/serial_transfer_unit_shift_reg.sv
// transfer_shift_reg: word holding register for the serialiser.
//   clk, reset   : clock, synchronous active-high reset (clears the word)
//   load         : take loadWord as the source word this edge
//   loadWord     : word to capture
//   advance      : consume one beat of the source word (shift left 1 or 2)
//   dual         : beat width select for advance (0: 1 bit, 1: 2 bits)
//   headPair     : top two bits of the source word (next beat to present)
// The source word is loadWord when load is high, otherwise the held word, so
// a capture and the first beat can happen on the same edge.
module transfer_shift_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] loadWord,
  input  logic                  advance,
  input  logic                  dual,
  output logic [1:0]            headPair
);

  logic [DATA_WIDTH-1:0] shReg;
  logic [DATA_WIDTH-1:0] srcWord;

  assign srcWord  = load ? loadWord : shReg;
  assign headPair = srcWord[DATA_WIDTH-1 -: 2];

  always_ff @(posedge clk) begin
    if (reset)        shReg <= '0;
    else if (advance) shReg <= dual ? (srcWord << 2) : (srcWord << 1);
    else if (load)    shReg <= loadWord;
  end

endmodule

// File: rtl/serial_transfer_unit.sv
// serial_transfer_unit: responder side of the Controller transfer handshake.
// Captures a memory word on SampleData, serialises it MSB-first on DataOut
// (1 or 2 bits per beat per Mode), then holds TransferDone for DONE_HOLD
// cycles. A request still held at the end parks in WAIT_REL until released,
// so one assertion of TransferData yields exactly one transfer.
//   Clk, Reset    : clock, synchronous active-high reset
//   SampleData    : capture DataIn (ignored while Busy)
//   TransferData  : start/hold request (level)
//   Mode          : lane width, sampled at the start edge only
//   DataIn        : memory read word
//   DataOut       : serial lanes (DataOut[1] = 0 in serial mode)
//   OutValid      : DataOut carries a beat
//   TransferDone  : transfer complete
//   Busy          : transfer in progress (SHIFT or DONE)
module serial_transfer_unit
  import serial_transfer_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DONE_HOLD  = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  SampleData,
  input  logic                  TransferData,
  input  logic                  Mode,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [1:0]            DataOut,
  output logic                  OutValid,
  output logic                  TransferDone,
  output logic                  Busy
);

  localparam int CNT_W  = $clog2(DATA_WIDTH);
  localparam int HOLD_W = $clog2(DONE_HOLD + 1);
  // beatCnt holds the beats still to come after the one on DataOut
  localparam logic [CNT_W-1:0]  LAST_SERIAL = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0]  LAST_DUAL   = CNT_W'(DATA_WIDTH / 2 - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(DONE_HOLD - 1);

  xferState_e        state;
  logic              modeQ;
  logic              armed;
  logic [CNT_W-1:0]  beatCnt;
  logic [HOLD_W-1:0] holdCnt;

  logic       startXfer;
  logic       srLoad;
  logic       srAdvance;
  logic       srDual;
  logic [1:0] headPair;
  logic [1:0] laneOut;

  assign startXfer = (state == IDLE) && TransferData && armed;
  // capture is allowed whenever the unit is not Busy
  assign srLoad    = SampleData && ((state == IDLE) || (state == WAIT_REL));
  assign srAdvance = startXfer || ((state == SHIFT) && (beatCnt != '0));
  // at the start edge the live Mode applies; afterwards the latched copy
  assign srDual    = (state == IDLE) ? Mode : modeQ;
  assign laneOut   = srDual ? headPair : {1'b0, headPair[1]};

  transfer_shift_reg #(.DATA_WIDTH(DATA_WIDTH)) uShiftReg (
    .clk      (Clk),
    .reset    (Reset),
    .load     (srLoad),
    .loadWord (DataIn),
    .advance  (srAdvance),
    .dual     (srDual),
    .headPair (headPair)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      modeQ        <= MODE_SERIAL;
      armed        <= 1'b1;
      beatCnt      <= '0;
      holdCnt      <= '0;
      DataOut      <= 2'b00;
      OutValid     <= 1'b0;
      TransferDone <= 1'b0;
      Busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (startXfer) begin
            modeQ    <= Mode;
            beatCnt  <= (Mode == MODE_DUAL) ? LAST_DUAL : LAST_SERIAL;
            DataOut  <= laneOut;
            OutValid <= 1'b1;
            Busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (beatCnt == '0) begin
            DataOut      <= 2'b00;
            OutValid     <= 1'b0;
            TransferDone <= 1'b1;
            holdCnt      <= HOLD_LAST;
            state        <= DONE;
          end else begin
            beatCnt <= beatCnt - 1'b1;
            DataOut <= laneOut;
          end
        end
        DONE: begin
          if (holdCnt == '0) begin
            TransferDone <= 1'b0;
            Busy         <= 1'b0;
            if (TransferData) begin
              armed <= 1'b0;
              state <= WAIT_REL;
            end else begin
              state <= IDLE;
            end
          end else begin
            holdCnt <= holdCnt - 1'b1;
          end
        end
        WAIT_REL: begin
          if (!TransferData) begin
            armed <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_transfer_unit.sv
module tb_serial_transfer_unit;

  localparam int DW = 8;
  localparam int DH = 3;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          SampleData = 1'b0;
  logic          TransferData = 1'b0;
  logic          Mode = 1'b0;
  logic [DW-1:0] DataIn = '0;
  logic [1:0]    DataOut;
  logic          OutValid;
  logic          TransferDone;
  logic          Busy;

  serial_transfer_unit #(.DATA_WIDTH(DW), .DONE_HOLD(DH)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .SampleData   (SampleData),
    .TransferData (TransferData),
    .Mode         (Mode),
    .DataIn       (DataIn),
    .DataOut      (DataOut),
    .OutValid     (OutValid),
    .TransferDone (TransferDone),
    .Busy         (Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0] dout;
    logic       valid;
    logic       done;
    logic       busy;
  } obs_t;

  int total = 0;
  int bad = 0;
  bit checkOn = 0;
  int edgeCnt = 0;

  // ---------------- reference model ----------------
  // A transfer is a list of per-cycle observations built at the start edge:
  // the beats of the word, then DH cycles of TransferDone.
  obs_t          sched[$];
  obs_t          expO = '0;
  logic [DW-1:0] mWord = '0;
  bit            mArmed = 1;
  bit            mBusy = 0;

  always @(posedge Clk) begin
    edgeCnt++;
    if (Reset) begin
      sched.delete();
      mWord = '0; mArmed = 1; mBusy = 0; expO = '0;
    end else if (sched.size() > 0) begin
      expO = sched.pop_front();
    end else if (mBusy) begin
      mBusy = 0; expO = '0;
      mArmed = !TransferData;
    end else begin
      if (SampleData) mWord = DataIn;
      if (!mArmed && !TransferData) mArmed = 1;
      else if (TransferData && mArmed) begin
        int n;
        obs_t o;
        n = Mode ? DW / 2 : DW;
        for (int i = 0; i < n; i++) begin
          o.dout  = Mode ? mWord[DW-1-2*i -: 2] : {1'b0, mWord[DW-1-i]};
          o.valid = 1; o.done = 0; o.busy = 1;
          sched.push_back(o);
        end
        for (int i = 0; i < DH; i++) sched.push_back(obs_t'(5'b00011));
        mBusy = 1;
        expO = sched.pop_front();
      end
    end
  end

  // ---------------- per-cycle compare + logging ----------------
  int   beatLog[$];
  int   doneCount = 0;
  int   riseEdge = 0;
  logic prevTd = 0;

  always @(negedge Clk) begin
    if (checkOn) begin
      total++;
      if ({DataOut, OutValid, TransferDone, Busy} !== expO) begin
        bad++;
        $display("FAIL cycle%0d out={dout,valid,done,busy} act=%b exp=%b",
                 edgeCnt, {DataOut, OutValid, TransferDone, Busy}, expO);
      end
      if (OutValid) beatLog.push_back(int'(DataOut));
      if (TransferDone) doneCount++;
      if (TransferDone && !prevTd) riseEdge = edgeCnt;
      prevTd = TransferDone;
    end
  end

  // ---------------- helpers ----------------
  int startEdge = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step(input bit sd, input bit td, input bit md, input logic [DW-1:0] din);
    SampleData = sd; TransferData = td; Mode = md; DataIn = din;
    if (td) startEdge = edgeCnt + 1;
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, '0);
  endtask

  task automatic clearLog();
    beatLog.delete();
    doneCount = 0;
  endtask

  function automatic logic [31:0] logVec();
    logic [31:0] v = 0;
    foreach (beatLog[i]) v = (v << 2) | 32'(beatLog[i]);
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1;
    @(posedge Clk);
    checkOn = 1;
    @(negedge Clk);
    @(negedge Clk);
    chk("reset_outputs", {27'b0, DataOut, OutValid, TransferDone, Busy}, 32'h0);
    Reset = 0;
    idle(2);

    // A5 serial: 1,0,1,0,0,1,0,1 then 3 cycles of done
    step(1, 0, 0, 8'hA5);
    clearLog();
    step(0, 1, 0, 8'h00);
    idle(14);
    chk("a5_serial_beats", beatLog.size(), 8);
    chk("a5_serial_data", logVec(), 32'h4411);
    chk("a5_serial_done_len", doneCount, DH);
    chk("a5_serial_done_rise", riseEdge - startEdge + 1, 9);
    chk("a5_serial_busy_after", Busy, 0);

    // A5 dual: 10,10,01,01; done rises 5 cycles after start edge
    step(1, 0, 0, 8'hA5);
    clearLog();
    step(0, 1, 1, 8'h00);
    idle(10);
    chk("a5_dual_beats", beatLog.size(), 4);
    chk("a5_dual_data", logVec(), 32'hA5);
    chk("a5_dual_done_rise", riseEdge - startEdge + 1, 5);
    chk("a5_dual_done_len", doneCount, DH);

    // Mode/DataIn/SampleData wiggling while busy has no effect
    step(1, 0, 0, 8'hA5);
    clearLog();
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(1, 0, ~i[0], 8'hFF);
    idle(8);
    chk("busy_ignore_beats", beatLog.size(), 8);
    chk("busy_ignore_data", logVec(), 32'h4411);

    // held request: one transfer, then parked until release
    step(1, 0, 0, 8'h81);
    clearLog();
    repeat (25) step(0, 1, 0, 8'h00);
    chk("held_single_beats", beatLog.size(), 8);
    chk("held_single_data", logVec(), 32'h4001);
    chk("held_not_busy", Busy, 0);
    step(0, 0, 0, 8'h00);
    step(1, 0, 0, 8'h0F);
    clearLog();
    step(0, 1, 0, 8'h00);
    idle(14);
    chk("rearm_beats", beatLog.size(), 8);
    chk("rearm_data", logVec(), 32'h0055);

    // capture and start on the same edge: capture wins
    clearLog();
    step(1, 1, 0, 8'h3C);
    idle(14);
    chk("same_edge_data", logVec(), 32'h0550);
    chk("same_edge_beats", beatLog.size(), 8);

    // reset mid-shift
    step(1, 0, 0, 8'hA5);
    step(0, 1, 0, 8'h00);
    idle(3);
    Reset = 1;
    idle(2);
    chk("midreset_outputs", {27'b0, DataOut, OutValid, TransferDone, Busy}, 32'h0);
    Reset = 0;

    // no capture after reset: eight zero beats, done still reported
    clearLog();
    step(0, 1, 0, 8'h00);
    idle(14);
    chk("zero_word_beats", beatLog.size(), 8);
    chk("zero_word_data", logVec(), 32'h0);
    chk("zero_word_done_len", doneCount, DH);

    // randomized traffic against the model
    begin
      bit td = 0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 5) == 0) td = ~td;
        Reset = ($urandom_range(0, 79) == 0);
        step(td ? 1'b1 : ($urandom_range(0, 3) == 0), td, 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)));
      end
    end
    Reset = 0;
    idle(16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
